// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, shift-unit state encoding and opcode legality.
package alu_pkg;

  localparam logic [2:0] FUN_LSR = 3'b000;
  localparam logic [2:0] FUN_LSL = 3'b001;
  localparam logic [2:0] FUN_ASR = 3'b010;
  localparam logic [2:0] FUN_ROR = 3'b011;
  localparam logic [2:0] FUN_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic fun_is_legal(input logic [2:0] fun);
    return (fun <= FUN_ROL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational step: applies n (0..STEP) single-bit shifts/rotates to work and tracks the carry.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int STEP = 1,
  parameter int NW   = 5
) (
  input  logic [2:0]    mode,
  input  logic [W-1:0]  work_in,
  input  logic          carry_in,
  input  logic [NW-1:0] n,
  output logic [W-1:0]  work_out,
  output logic          carry_out
);

  // Unrolled chain of single-bit moves; positions beyond n pass through untouched.
  always_comb begin
    work_out  = work_in;
    carry_out = carry_in;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(n)) begin
        case (mode)
          FUN_LSR: begin
            carry_out = work_out[0];
            work_out  = {1'b0, work_out[W-1:1]};
          end
          FUN_LSL: begin
            carry_out = work_out[W-1];
            work_out  = {work_out[W-2:0], 1'b0};
          end
          FUN_ASR: begin
            carry_out = work_out[0];
            work_out  = {work_out[W-1], work_out[W-1:1]};
          end
          FUN_ROR: begin
            carry_out = work_out[0];
            work_out  = {work_out[0], work_out[W-1:1]};
          end
          FUN_ROL: begin
            carry_out = work_out[W-1];
            work_out  = {work_out[W-2:0], work_out[W-1]};
          end
          default: begin
            carry_out = carry_out;
            work_out  = work_out;
          end
        endcase
      end else begin
        carry_out = carry_out;
        work_out  = work_out;
      end
    end
  end

endmodule

// File: rtl/alu_iter_shift_unit.sv
// Multi-cycle shift/rotate unit: IDLE/SHIFT/DONE control, remain down-counter,
// working registers and fully registered result/status outputs.
module alu_iter_shift_unit
  import alu_pkg::*;
#(
  parameter int Op_Width = 16,
  parameter int STEP     = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [Op_Width-1:0]         A,
  input  logic [Op_Width-1:0]         B,
  input  logic                        Src_Sel,
  input  logic [2:0]                  ALU_FUN,
  input  logic [$clog2(Op_Width)-1:0] Shift_Amt,
  input  logic                        Shift_En,
  output logic                        Shift_Busy,
  output logic [Op_Width-1:0]         Shift_Out,
  output logic                        Shift_Carry,
  output logic                        Shift_Zero,
  output logic                        Shift_Flag,
  output logic                        Shift_Err
);

  localparam int SH_W = $clog2(Op_Width);
  localparam logic [SH_W:0] STEP_N = (SH_W + 1)'(STEP);

  state_e              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [Op_Width-1:0] work_q, work_d;
  logic [SH_W-1:0]     remain_q, remain_d;
  logic                carry_w_q, carry_w_d;
  logic [Op_Width-1:0] out_q, out_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                flag_q, flag_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [SH_W:0]       step_n;
  logic [Op_Width-1:0] step_work;
  logic                step_carry;

  alu_shift_step #(
    .W    (Op_Width),
    .STEP (STEP),
    .NW   (SH_W + 1)
  ) u_step (
    .mode      (mode_q),
    .work_in   (work_q),
    .carry_in  (carry_w_q),
    .n         (step_n),
    .work_out  (step_work),
    .carry_out (step_carry)
  );

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    work_d    = work_q;
    remain_d  = remain_q;
    carry_w_d = carry_w_q;
    out_d     = out_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    flag_d    = 1'b0;
    err_d     = 1'b0;
    // Widened compare so STEP == Op_Width still fits.
    step_n    = ({1'b0, remain_q} > STEP_N) ? STEP_N : {1'b0, remain_q};

    case (state_q)
      ST_IDLE: begin
        if (Shift_En) begin
          if (fun_is_legal(ALU_FUN)) begin
            mode_d    = ALU_FUN;
            work_d    = Src_Sel ? B : A;
            remain_d  = Shift_Amt;
            carry_w_d = 1'b0;
            state_d   = (Shift_Amt != {SH_W{1'b0}}) ? ST_SHIFT : ST_DONE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d    = step_work;
        carry_w_d = step_carry;
        remain_d  = remain_q - step_n[SH_W-1:0];
        state_d   = (remain_d == {SH_W{1'b0}}) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        out_d   = work_q;
        carry_d = carry_w_q;
        zero_d  = (work_q == {Op_Width{1'b0}});
        flag_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, working and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      mode_q    <= 3'b000;
      work_q    <= {Op_Width{1'b0}};
      remain_q  <= {SH_W{1'b0}};
      carry_w_q <= 1'b0;
      out_q     <= {Op_Width{1'b0}};
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
      remain_q  <= remain_d;
      carry_w_q <= carry_w_d;
      out_q     <= out_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign Shift_Busy  = busy_q;
  assign Shift_Out   = out_q;
  assign Shift_Carry = carry_q;
  assign Shift_Zero  = zero_q;
  assign Shift_Flag  = flag_q;
  assign Shift_Err   = err_q;

endmodule
